ifetch_stage: RTL

IFETCH_STAGE -- requirements
Module: ifetch_stage

---
 rtl/ifetch_pkg.sv | 31 +++
 rtl/ifetch_pc_reg.sv | 32 +++
 rtl/ifetch_stage.sv | 132 +++++++++++++
 3 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// The FAULT state exists only when IFETCH_ALIGN_CHECK_EN is defined.
package ifetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
    localparam logic [31:0] PC_INC           = 32'd4;

`ifdef IFETCH_ALIGN_CHECK_EN
    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_t;
`else
    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1
    } fetch_state_t;
`endif

    typedef enum logic [1:0] {
        NPC_HOLD     = 2'd0,
        NPC_INC      = 2'd1,
        NPC_REDIRECT = 2'd2
    } npc_sel_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/ifetch_pc_reg.sv
// Fetch PC register with its next-pc mux (hold / +4 / redirect target).
// Alignment of the redirect target is the caller's concern (see IFETCH_ALIGN_CHECK_EN).
module ifetch_pc_reg
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  sel,
    input  logic [31:0] target,
    output logic [31:0] pc
);

    logic [31:0] pc_r;

    // PC update: reset vector, sequential advance, or redirect target.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_r <= RESET_PC;
        end else begin
            case (sel)
                NPC_INC:      pc_r <= pc_r + PC_INC;
                NPC_REDIRECT: pc_r <= target;
                default:      pc_r <= pc_r;
            endcase
        end
    end

    assign pc = pc_r;

endmodule

// File: rtl/ifetch_stage.sv
// Instruction fetch stage: BOOT/RUN FSM, output holding register, redirect handling.
// Define IFETCH_ALIGN_CHECK_EN to trap misaligned redirect targets in a FAULT state.
module ifetch_stage
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          IMEM_AW  = 11
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    input  logic               out_ready,
    output logic               imem_r,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_data,
    output logic               out_valid,
    output logic [31:0]        out_pc,
    output logic [31:0]        out_instr,
    output logic               fault
);

    fetch_state_t state_r;
    logic         out_valid_r;
    logic [31:0]  out_pc_r;
    logic [31:0]  out_instr_r;
    logic [31:0]  pc_s;
    logic [31:0]  target_s;
    logic [1:0]   npc_sel_s;
    logic         load_s;

`ifdef IFETCH_ALIGN_CHECK_EN
    logic fault_r;
    logic misaligned_s;

    assign misaligned_s = (redirect_pc[1:0] != 2'b00);
    assign target_s     = redirect_pc;
    assign fault        = fault_r;
`else
    assign target_s = word_align(redirect_pc);
    assign fault    = 1'b0;
`endif

    // A redirect suppresses the load in the same cycle.
    assign load_s = (state_r == ST_RUN) && !redirect_valid && (!out_valid_r || out_ready);

    // Next-pc selection: redirect beats load, which beats hold.
    always_comb begin
        npc_sel_s = NPC_HOLD;
        if (redirect_valid) begin
            npc_sel_s = NPC_REDIRECT;
        end else if (load_s) begin
            npc_sel_s = NPC_INC;
        end else begin
            npc_sel_s = NPC_HOLD;
        end
    end

    ifetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .sel    (npc_sel_s),
        .target (target_s),
        .pc     (pc_s)
    );

    // Fetch FSM and output register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_BOOT;
            out_valid_r <= 1'b0;
            out_pc_r    <= 32'd0;
            out_instr_r <= 32'd0;
`ifdef IFETCH_ALIGN_CHECK_EN
            fault_r     <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_BOOT: begin
                    out_valid_r <= 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
                    if (redirect_valid && misaligned_s) begin
                        state_r <= ST_FAULT;
                        fault_r <= 1'b1;
                    end else begin
                        state_r <= ST_RUN;
                    end
`else
                    state_r <= ST_RUN;
`endif
                end
                ST_RUN: begin
                    if (redirect_valid) begin
                        out_valid_r <= 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
                        if (misaligned_s) begin
                            state_r <= ST_FAULT;
                            fault_r <= 1'b1;
                        end
`endif
                    end else if (load_s) begin
                        out_valid_r <= 1'b1;
                        out_pc_r    <= pc_s;
                        out_instr_r <= imem_data;
                    end
                end
`ifdef IFETCH_ALIGN_CHECK_EN
                ST_FAULT: begin
                    out_valid_r <= 1'b0;
                    if (redirect_valid && !misaligned_s) begin
                        state_r <= ST_RUN;
                        fault_r <= 1'b0;
                    end
                end
`endif
                default: begin
                    state_r     <= ST_BOOT;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign imem_r    = (state_r == ST_RUN);
    assign imem_addr = IMEM_AW'((pc_s - RESET_PC) >> 2);
    assign out_valid = out_valid_r;
    assign out_pc    = out_pc_r;
    assign out_instr = out_instr_r;

endmodule
